backprop_layer_scheduler: RTL
=============================

# backprop_layer_scheduler

Sequences the backward pass of the layer-multiplexed network through the shared weight controller. On a start handshake it walks the layer address from the last layer down to layer 0. For each layer it waits for the weight BRAM read to settle, admits exactly one z vector and one delta vector into the weight controller, and waits for the weight update to be written back before moving to the next layer. It sits between the z/delta producers and the weight controller, and owns that controller's `layer` input.

## Interface
Parameters:
- LAYER_NUM, 3: number of layers stored in the weight BRAM; must be ≥ 1.
- LAYER_ADDR_WIDTH, 2: width of `layer`; 2^LAYER_ADDR_WIDTH ≥ LAYER_NUM.
- SETTLE_CYCLES, 2: cycles `layer` is held stable before z/delta are admitted; covers the 1-cycle BRAM read latency plus margin; must be ≥ 1.
- TIMEOUT_CYCLES, 64: maximum wait for `update_done` per layer.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- start_valid  in  1  request for a backward pass.
- start_ready  out  1  high only in IDLE with `rst` low.
- layer  out  LAYER_ADDR_WIDTH  layer address to the weight controller.
- z_in_valid / z_in_ready  in / out  1  upstream z handshake.
- z_out_valid / z_out_ready  out / in  1  z handshake to the weight controller; data bypasses this block.
- delta_in_valid / delta_in_ready  in / out  1  upstream delta handshake.
- delta_out_valid / delta_out_ready  out / in  1  delta handshake to the weight controller.
- update_done  in  1  one-cycle strobe from the updater's result-valid, marking the BRAM write.
- update_error  in  1  updater overflow flag; sampled while `update_done` is high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass ends.
- err  out  1  sticky: set by an overflow or a timeout; cleared on `rst` or on start acceptance.
- err_layer  out  LAYER_ADDR_WIDTH  layer of the first error of the current pass.
- timeout  out  1  sticky: set when a layer times out; cleared with `err`.

## Operation
- States: IDLE, SETTLE, TRANSFER, WAIT_UPDATE, DONE.
- IDLE:
  - start accepted when start_valid & start_ready.
  - On acceptance: layer ← LAYER_NUM-1, clear err/timeout/err_layer, settle counter ← 0, next state SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1: go to TRANSFER and clear the z_taken/delta_taken flags.
- TRANSFER:
  - z_out_valid = z_in_valid & !z_taken.
  - z_in_ready = z_out_ready & !z_taken.
  - Delta path is identical, using delta_taken.
  - A flag sets on its out-side handshake. The z and delta paths complete independently and in either order, including the same cycle.
  - When both flags are set (counting a flag that sets this cycle): go to WAIT_UPDATE with the timeout counter ← 0.
- Outside TRANSFER, all four gated handshake outputs are 0 and upstream stalls.
- WAIT_UPDATE, on update_done:
  - If update_error is high and err is clear: set err and capture err_layer.
  - If layer == 0: go to DONE.
  - Otherwise: decrement layer and go to SETTLE.
- WAIT_UPDATE, timeout counter reaching TIMEOUT_CYCLES-1 with no update_done:
  - Set timeout.
  - Set err and capture err_layer if err is clear.
  - Advance exactly as for update_done.
- update_done outside WAIT_UPDATE is ignored, including an early strobe in TRANSFER.
- DONE: done = 1 for one cycle, then IDLE.
- rst mid-pass: the next state is IDLE and all outputs take their reset values. A partially admitted z/delta pair is dropped; upstream must also be reset.
- LAYER_NUM = 1: a single SETTLE/TRANSFER/WAIT_UPDATE round, then DONE.

## Timing
- Reset values: layer=0, busy=0, done=0, err=0, err_layer=0, timeout=0, all gated valid/ready outputs 0, start_ready=0 while rst is high.
- layer, busy, done, err, err_layer and timeout are registered. The gated handshakes are combinational from the state, the flags and the partner handshake signals.
- Start acceptance in cycle t: busy=1 and the new layer are visible at t+1; first possible z/delta transfer at t+1+SETTLE_CYCLES.
- update_done in cycle u: the next layer is visible at u+1 and TRANSFER reopens at u+1+SETTLE_CYCLES.
- The BRAM write lands in cycle u. SETTLE_CYCLES ≥ 1 guarantees the next read-address change follows the write.
- Total pass latency with zero-wait producers and updater response R cycles: LAYER_NUM·(SETTLE_CYCLES+1+R) + 2 cycles.

## Structure
- Shared package: state enum `sched_state_t`. LAYER_ADDR_WIDTH is already shared with the weight controller.
- The combined settle/timeout counter is a natural sub-module: `sched_cycle_counter` (load, enable, terminal-count compare).
- No datapath; z and delta buses wire directly from producers to the weight controller.

## Test plan
- LAYER_NUM=3, SETTLE_CYCLES=2, update_done 3 cycles after the transfer → layer sequence 2,1,0; done pulses once; err=0.
- z handshake in TRANSFER cycle 1, delta held off until cycle 4 → z_in_ready=0 after the z handshake; transition to WAIT_UPDATE only after the delta handshake.
- update_done strobed during SETTLE and during TRANSFER → ignored; layer unchanged until a strobe arrives in WAIT_UPDATE.
- update_error=1 with update_done at layer 1, and again at layer 0 → err=1, err_layer=1 (first error kept), done still pulses.
- No update_done, TIMEOUT_CYCLES=8 → timeout=1 eight cycles after WAIT_UPDATE is entered; the pass advances to the next layer.
- rst asserted in WAIT_UPDATE at layer 1 → next cycle busy=0, layer=0, err=0, start_ready=1 once rst is low.

Source files
------------

// File: rtl/backprop_layer_scheduler_pkg.sv
// Shared types for the backward-pass layer scheduler.
// The layer address width matches the weight controller's default.
package backprop_layer_scheduler_pkg;

  localparam int SCHED_LAYER_ADDR_WIDTH = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_TRANSFER,
    S_WAIT_UPDATE,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/backprop_layer_scheduler_cycle_counter.sv
// Shared settle/timeout cycle counter.
// Counts up from zero and flags the selected terminal count.
module sched_cycle_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/backprop_layer_scheduler.sv
// Walks the weight controller's layer address from last to first,
// admitting one z/delta pair per layer and waiting for its write-back.
module backprop_layer_scheduler
  import backprop_layer_scheduler_pkg::*;
#(
  parameter int LAYER_NUM        = 3,
  parameter int LAYER_ADDR_WIDTH = SCHED_LAYER_ADDR_WIDTH,
  parameter int SETTLE_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_valid,
  output logic                        start_ready,
  output logic [LAYER_ADDR_WIDTH-1:0] layer,
  input  logic                        z_in_valid,
  output logic                        z_in_ready,
  output logic                        z_out_valid,
  input  logic                        z_out_ready,
  input  logic                        delta_in_valid,
  output logic                        delta_in_ready,
  output logic                        delta_out_valid,
  input  logic                        delta_out_ready,
  input  logic                        update_done,
  input  logic                        update_error,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [LAYER_ADDR_WIDTH-1:0] err_layer,
  output logic                        timeout
);

  localparam int CNT_MAX =
    (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] SETTLE_TC  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_TC = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_LAYER =
    LAYER_ADDR_WIDTH'(LAYER_NUM - 1);

  sched_state_t state, state_n;

  logic          z_taken, delta_taken;
  logic          z_fire, delta_fire;
  logic          in_xfer;
  logic          accept, advance, tmo_hit;
  logic          cnt_load, cnt_en, cnt_term;
  logic [CW-1:0] cnt_tc, cnt;

  // The counter restarts on every state change; only SETTLE and
  // WAIT_UPDATE consume its terminal flag.
  assign cnt_load = (state_n != state);
  assign cnt_en   = (state == S_SETTLE) || (state == S_WAIT_UPDATE);
  assign cnt_tc   = (state == S_SETTLE) ? SETTLE_TC : TIMEOUT_TC;

  sched_cycle_counter #(
    .WIDTH(CW)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .enable     (cnt_en),
    .terminal   (cnt_tc),
    .count      (cnt),
    .at_terminal(cnt_term)
  );

  assign start_ready = (state == S_IDLE) && !rst;
  assign in_xfer     = (state == S_TRANSFER) && !rst;

  assign z_out_valid     = in_xfer && z_in_valid && !z_taken;
  assign z_in_ready      = in_xfer && z_out_ready && !z_taken;
  assign delta_out_valid = in_xfer && delta_in_valid && !delta_taken;
  assign delta_in_ready  = in_xfer && delta_out_ready && !delta_taken;

  assign z_fire     = z_out_valid && z_out_ready;
  assign delta_fire = delta_out_valid && delta_out_ready;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    advance = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_valid && start_ready) begin
          accept  = 1'b1;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_term)
          state_n = S_TRANSFER;
      end
      S_TRANSFER: begin
        if ((z_taken || z_fire) && (delta_taken || delta_fire))
          state_n = S_WAIT_UPDATE;
      end
      S_WAIT_UPDATE: begin
        if (update_done || cnt_term) begin
          advance = 1'b1;
          tmo_hit = !update_done;
          state_n = (layer == '0) ? S_DONE : S_SETTLE;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (rst)
      state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      layer       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_layer   <= '0;
      timeout     <= 1'b0;
      z_taken     <= 1'b0;
      delta_taken <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != S_IDLE);
      done  <= (state_n == S_DONE);
      if (accept) begin
        layer     <= LAST_LAYER;
        err       <= 1'b0;
        err_layer <= '0;
        timeout   <= 1'b0;
      end
      if (state == S_SETTLE && state_n == S_TRANSFER) begin
        z_taken     <= 1'b0;
        delta_taken <= 1'b0;
      end else begin
        if (z_fire)
          z_taken <= 1'b1;
        if (delta_fire)
          delta_taken <= 1'b1;
      end
      if (advance) begin
        if (layer != '0)
          layer <= layer - 1'b1;
        // Only the first failure of a pass is attributed.
        if ((tmo_hit || update_error) && !err) begin
          err       <= 1'b1;
          err_layer <= layer;
        end
        if (tmo_hit)
          timeout <= 1'b1;
      end
    end
  end

endmodule
